// File: rtl/cla_64bit_if.sv
// cla_64bit_if: operand/result bundle for the 64-bit carry-lookahead adder.
//   A, B, Cin                 : operands and carry into bit 0 (driven by master)
//   Result, Cout, Overflow    : registered sum and flags (driven by slave/adder)
interface cla_64bit_if;
    logic [63:0] A;
    logic [63:0] B;
    logic        Cin;
    logic [63:0] Result;
    logic        Cout;
    logic        Overflow;

    modport master (
        output A, B, Cin,
        input  Result, Cout, Overflow
    );

    modport slave (
        input  A, B, Cin,
        output Result, Cout, Overflow
    );
endinterface

// File: rtl/cla_64bit.sv
// cla_64bit: 64-bit hierarchical carry-lookahead adder with one output register stage.
// Ports:
//   clk    : rising-edge clock for the output registers
//   rst_n  : asynchronous active-low reset, clears Result/Cout/Overflow
//   bus    : cla_64bit_if.slave
//            A, B, Cin in  -> Result = A + B + Cin mod 2^64,
//            Cout = carry out of bit 63, Overflow = signed overflow (c[63] ^ c[64]).
// Structure: sixteen 4-bit lookahead blocks, four 16-bit lookahead sections,
// one top lookahead unit. Every carry is produced by a 4-wide lookahead from
// a carry computed one level up, so nothing ripples across a 4-bit block.
module cla_64bit (
    input  logic            clk,
    input  logic            rst_n,
    cla_64bit_if.slave      bus
);

    // 4-wide lookahead: carries into positions 0..3 given generate/propagate
    // and the carry into position 0. Used at bit, block and section level.
    function automatic logic [3:0] la4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Group generate of four lookahead positions.
    function automatic logic grp_g(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    logic [63:0] g_s;
    logic [63:0] p_s;
    logic [15:0] bg_s;      // block generate
    logic [15:0] bp_s;      // block propagate
    logic [3:0]  sg_s;      // section generate
    logic [3:0]  sp_s;      // section propagate
    logic        top_g_s;
    logic        top_p_s;
    logic [3:0]  sc_s;      // carry into each 16-bit section
    logic [15:0] bc_s;      // carry into each 4-bit block
    logic [64:0] c_s;       // carry into each bit, c_s[64] is carry out
    logic [63:0] sum_s;

    logic [63:0] result_d;
    logic        cout_d;
    logic        overflow_d;
    logic [63:0] result_q;
    logic        cout_q;
    logic        overflow_q;

    // Lookahead tree: G/P flows up the levels, carries flow back down.
    always_comb begin
        g_s        = 64'd0;
        p_s        = 64'd0;
        bg_s       = 16'd0;
        bp_s       = 16'd0;
        sg_s       = 4'd0;
        sp_s       = 4'd0;
        top_g_s    = 1'b0;
        top_p_s    = 1'b0;
        sc_s       = 4'd0;
        bc_s       = 16'd0;
        c_s        = 65'd0;
        sum_s      = 64'd0;
        result_d   = 64'd0;
        cout_d     = 1'b0;
        overflow_d = 1'b0;

        g_s = bus.A & bus.B;
        p_s = bus.A ^ bus.B;

        for (int k = 0; k < 16; k++) begin
            bg_s[k] = grp_g(g_s[4*k +: 4], p_s[4*k +: 4]);
            bp_s[k] = &p_s[4*k +: 4];
        end

        for (int s = 0; s < 4; s++) begin
            sg_s[s] = grp_g(bg_s[4*s +: 4], bp_s[4*s +: 4]);
            sp_s[s] = &bp_s[4*s +: 4];
        end

        top_g_s = grp_g(sg_s, sp_s);
        top_p_s = &sp_s;

        sc_s    = la4(sg_s, sp_s, bus.Cin);
        c_s[64] = top_g_s | (top_p_s & bus.Cin);

        for (int s = 0; s < 4; s++) begin
            bc_s[4*s +: 4] = la4(bg_s[4*s +: 4], bp_s[4*s +: 4], sc_s[s]);
        end

        for (int k = 0; k < 16; k++) begin
            c_s[4*k +: 4] = la4(g_s[4*k +: 4], p_s[4*k +: 4], bc_s[k]);
        end

        sum_s      = p_s ^ c_s[63:0];
        result_d   = sum_s;
        cout_d     = c_s[64];
        overflow_d = c_s[63] ^ c_s[64];
    end

    // Output register stage; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= 64'd0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.Result   = result_q;
    assign bus.Cout     = cout_q;
    assign bus.Overflow = overflow_q;

endmodule

// File: tb/tb_cla_64bit.sv
// tb_cla_64bit: directed and random checks of cla_64bit.
module tb_cla_64bit;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    cla_64bit_if bus_if ();

    cla_64bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply operands at a falling edge, then wait one full cycle so the
    // following rising edge has captured them.
    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic ci);
        @(negedge clk);
        bus_if.A   = a;
        bus_if.B   = b;
        bus_if.Cin = ci;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n      = 1'b1;
        bus_if.A   = 64'd5;
        bus_if.B   = 64'd7;
        bus_if.Cin = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        compared++;
        if ({bus_if.Result, bus_if.Cout, bus_if.Overflow} !== 66'd0) begin
            mismatched++;
            $display("FAIL reset_async: got R=%h C=%b V=%b want all 0", bus_if.Result, bus_if.Cout, bus_if.Overflow);
        end
        @(negedge clk);
        compared++;
        if ({bus_if.Result, bus_if.Cout, bus_if.Overflow} !== 66'd0) begin
            mismatched++;
            $display("FAIL reset_hold: got R=%h want 0", bus_if.Result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (bus_if.Result !== 64'd12) begin
            mismatched++;
            $display("FAIL reset_release: got R=%0d want 12", bus_if.Result);
        end
    endtask

    task automatic test_flags();
        // full carry chain
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        compared++;
        if ({bus_if.Result, bus_if.Cout, bus_if.Overflow} !== {64'd0, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL carry_chain: got R=%h C=%b V=%b want R=0 C=1 V=0", bus_if.Result, bus_if.Cout, bus_if.Overflow);
        end
        // positive overflow
        drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        compared++;
        if ({bus_if.Result, bus_if.Cout, bus_if.Overflow} !== {64'h8000_0000_0000_0000, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL pos_overflow: got R=%h C=%b V=%b want R=8000000000000000 C=0 V=1", bus_if.Result, bus_if.Cout, bus_if.Overflow);
        end
        // carry-in
        drive(64'd1, 64'd1, 1'b1);
        compared++;
        if ({bus_if.Result, bus_if.Cout, bus_if.Overflow} !== {64'd3, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL carry_in: got R=%h C=%b V=%b want R=3 C=0 V=0", bus_if.Result, bus_if.Cout, bus_if.Overflow);
        end
        // negative overflow
        drive(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        compared++;
        if ({bus_if.Result, bus_if.Cout, bus_if.Overflow} !== {64'd0, 1'b1, 1'b1}) begin
            mismatched++;
            $display("FAIL neg_overflow: got R=%h C=%b V=%b want R=0 C=1 V=1", bus_if.Result, bus_if.Cout, bus_if.Overflow);
        end
    endtask

    task automatic test_subtract();
        drive(64'd10, ~64'd3, 1'b1);
        compared++;
        if ({bus_if.Result, bus_if.Cout, bus_if.Overflow} !== {64'd7, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL subtract: got R=%h C=%b V=%b want R=7 C=1 V=0", bus_if.Result, bus_if.Cout, bus_if.Overflow);
        end
        // 3 - 10 = -7, borrow means Cout = 0
        drive(64'd3, ~64'd10, 1'b1);
        compared++;
        if ({bus_if.Result, bus_if.Cout, bus_if.Overflow} !== {64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0}) begin
            mismatched++;
            $display("FAIL subtract_neg: got R=%h C=%b V=%b want R=FFFFFFFFFFFFFFF9 C=0 V=0", bus_if.Result, bus_if.Cout, bus_if.Overflow);
        end
    endtask

    task automatic test_boundaries();
        logic [63:0] a_t [6];
        logic [63:0] r_t [6];
        a_t[0] = 64'h0000_0000_0000_000F;  r_t[0] = 64'h0000_0000_0000_0010;
        a_t[1] = 64'h0000_0000_0000_FFFF;  r_t[1] = 64'h0000_0000_0001_0000;
        a_t[2] = 64'h0000_0000_FFFF_FFFF;  r_t[2] = 64'h0000_0001_0000_0000;
        a_t[3] = 64'h0000_FFFF_FFFF_FFFF;  r_t[3] = 64'h0001_0000_0000_0000;
        a_t[4] = 64'h0FFF_FFFF_FFFF_FFFF;  r_t[4] = 64'h1000_0000_0000_0000;
        a_t[5] = 64'h0000_0000_00FF_FFFF;  r_t[5] = 64'h0000_0000_0100_0000;
        for (int i = 0; i < 6; i++) begin
            drive(a_t[i], 64'd1, 1'b0);
            compared++;
            if ({bus_if.Result, bus_if.Cout, bus_if.Overflow} !== {r_t[i], 1'b0, 1'b0}) begin
                mismatched++;
                $display("FAIL boundary_%0d: got R=%h C=%b V=%b want R=%h C=0 V=0", i, bus_if.Result, bus_if.Cout, bus_if.Overflow, r_t[i]);
            end
        end
    endtask

    task automatic test_hold();
        drive(64'd40, 64'd2, 1'b0);
        bus_if.A = 64'd1000;
        bus_if.B = 64'd1000;
        #3;
        compared++;
        if (bus_if.Result !== 64'd42) begin
            mismatched++;
            $display("FAIL hold_between_edges: got R=%0d want 42", bus_if.Result);
        end
    endtask

    task automatic test_mid_reset();
        drive(64'd100, 64'd200, 1'b0);
        compared++;
        if (bus_if.Result !== 64'd300) begin
            mismatched++;
            $display("FAIL mid_reset_pre: got R=%0d want 300", bus_if.Result);
        end
        #1 rst_n = 1'b0;
        #1;
        compared++;
        if (bus_if.Result !== 64'd0) begin
            mismatched++;
            $display("FAIL mid_reset_clear: got R=%0d want 0", bus_if.Result);
        end
        bus_if.A = 64'd1;
        bus_if.B = 64'd2;
        #1 rst_n = 1'b1;
        #1;
        compared++;
        if (bus_if.Result !== 64'd0) begin
            mismatched++;
            $display("FAIL mid_reset_no_reappear: got R=%0d want 0", bus_if.Result);
        end
        @(negedge clk);
        compared++;
        if (bus_if.Result !== 64'd3) begin
            mismatched++;
            $display("FAIL mid_reset_release: got R=%0d want 3", bus_if.Result);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a;
        logic [63:0] b;
        logic        ci;
        logic [64:0] exp_sum;
        logic        exp_v;
        logic        have_exp;
        have_exp = 1'b0;
        exp_sum  = 65'd0;
        exp_v    = 1'b0;
        for (int i = 0; i <= 10000; i++) begin
            @(negedge clk);
            if (have_exp) begin
                compared++;
                if (bus_if.Result !== exp_sum[63:0]) begin
                    mismatched++;
                    $display("FAIL b2b_result[%0d]: got %h want %h", i, bus_if.Result, exp_sum[63:0]);
                end
                compared++;
                if (bus_if.Cout !== exp_sum[64]) begin
                    mismatched++;
                    $display("FAIL b2b_cout[%0d]: got %b want %b", i, bus_if.Cout, exp_sum[64]);
                end
                compared++;
                if (bus_if.Overflow !== exp_v) begin
                    mismatched++;
                    $display("FAIL b2b_overflow[%0d]: got %b want %b", i, bus_if.Overflow, exp_v);
                end
            end
            if (i < 10000) begin
                a  = {$urandom, $urandom};
                b  = {$urandom, $urandom};
                ci = 1'($urandom_range(1, 0));
                // all-propagate operands stress the longest carry path
                if ((i % 8) == 0) b = ~a;
                if ((i % 8) == 1) begin
                    a = 64'hFFFF_FFFF_FFFF_FFFF >> $urandom_range(63, 0);
                    b = 64'd1;
                end
                bus_if.A   = a;
                bus_if.B   = b;
                bus_if.Cin = ci;
                exp_sum  = {1'b0, a} + {1'b0, b} + {64'd0, ci};
                exp_v    = (a[63] == b[63]) && (exp_sum[63] != a[63]);
                have_exp = 1'b1;
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_flags();
        test_subtract();
        test_boundaries();
        test_hold();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cla_64bit.md
# cla_64bit

64-bit carry-lookahead adder for the RISC-V datapath ALU. It adds two 64-bit two's-complement operands plus a carry-in and produces a 64-bit sum, carry-out and signed-overflow flag. The adder core is a hierarchical lookahead structure, not ripple. It is followed by one output register stage so the block fits a single-cycle slot with registered outputs.

## Interface
- No parameters; width fixed at 64.
- clk  input  1  rising-edge clock for the output register stage
- rst_n  input  1  asynchronous active-low reset
- A  input  64  operand A, signed two's complement
- B  input  64  operand B, signed two's complement
- Cin  input  1  carry into bit 0
- Result  output  64  registered sum, A + B + Cin mod 2^64
- Cout  output  1  registered carry out of bit 63
- Overflow  output  1  registered signed overflow flag

## Operation
- Bit level:
  - g[i] = A[i] & B[i]
  - p[i] = A[i] ^ B[i]
  - sum[i] = p[i] ^ c[i], with c[0] = Cin
- Level 1: sixteen 4-bit lookahead blocks. Each produces its internal carries plus group G/P:
  - G = g3 | p3g2 | p3p2g1 | p3p2p1g0
  - P = p3p2p1p0
- Level 2: four 16-bit lookahead units. Each combines four block G/P into carries at each block boundary and emits section G/P.
- Level 3: one top lookahead unit. It computes carries into bits 16, 32 and 48, plus c[64] = G_top | P_top & Cin.
- No carry may ripple across more than one 4-bit block.
- Flags:
  - Cout = c[64]
  - Overflow = c[63] ^ c[64]. This is equivalent to A[63] == B[63] with sum[63] != A[63].
- Overflow is meaningful for signed operation. Cout is meaningful for unsigned operation. Both are always computed; no mode input.
- Subtraction is the caller's job: it drives B = ~operand and Cin = 1.
- Combinational sum, c[64] and overflow feed the output registers.

## Timing
- Inputs are sampled on every rising clk edge. There is no valid or handshake.
- Throughput is one addition per cycle.
- Latency is 1 cycle: values present before edge N appear on Result/Cout/Overflow after edge N and hold until edge N+1.
- The combinational path A/B/Cin → register D must meet one clock period. Logic depth is about 3 lookahead levels plus XOR.
- rst_n low asynchronously forces Result = 0, Cout = 0, Overflow = 0, regardless of clk.
- While rst_n is low, outputs hold 0. Deasserting rst_n takes effect on the next rising edge, which captures current inputs.
- Reset asserted mid-stream discards the in-flight result. It does not reappear after release.
- Inputs changing between edges have no effect on outputs until the next edge.

## Test plan
- Reset: rst_n = 0 with A = 5, B = 7 applied, no clock edge → Result = 0, Cout = 0, Overflow = 0. Release rst_n, apply 1 clock → Result = 12.
- Full carry chain: A = FFFF_FFFF_FFFF_FFFF, B = 1, Cin = 0, one edge → Result = 0, Cout = 1, Overflow = 0.
- Positive overflow: A = 7FFF_FFFF_FFFF_FFFF, B = 1, Cin = 0 → Result = 8000_0000_0000_0000, Cout = 0, Overflow = 1.
- Carry-in: A = 1, B = 1, Cin = 1 → Result = 3, Cout = 0, Overflow = 0.
- Negative overflow: A = B = 8000_0000_0000_0000, Cin = 0 → Result = 0, Cout = 1, Overflow = 1.
- Subtraction and back-to-back:
  - A = 10, B = ~3, Cin = 1 → Result = 7, Cout = 1, Overflow = 0.
  - Then 10,000 random vectors on consecutive cycles, checked one cycle later against {Cout, Result} = A + B + Cin (65-bit).
  - Overflow is checked against the sign rule.
  - Block-boundary patterns are included, e.g. A = 0000_0000_0000_FFFF, B = 1 → Result = 0000_0000_0001_0000.
